// File: rtl/activate_unit.sv
// Element-wise activation stage: captures one dense-layer output vector and sideband,
// produces the activated vector and its derivative one element per cycle, then holds them.
module activate_unit #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int frac_bits              = 8,
    parameter int act_type_size          = 4,
    parameter int dense_type_size        = 4,
    parameter int cost_type_size         = 8,
    parameter int backprop_controll_size = 66
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [act_type_size-1:0]          act_type,
    input  logic [data_size*size-1:0]         y,
    input  logic [dense_type_size-1:0]        dense_type,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [data_size*size-1:0]         predict_value,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [data_size*size-1:0]         a_out,
    output logic [data_size*size-1:0]         d_out,
    output logic [data_size*size-1:0]         y_out,
    output logic [act_type_size-1:0]          act_type_out,
    output logic [dense_type_size-1:0]        dense_type_out,
    output logic [cost_type_size-1:0]         cost_type_out,
    output logic [data_size*size-1:0]         predict_value_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int IDXW  = (size > 1) ? $clog2(size) : 1;
    localparam int ONE_I = 1 << frac_bits;

    localparam logic [IDXW-1:0] LAST = IDXW'(size - 1);

    localparam logic [act_type_size-1:0] ACT_RELU  = act_type_size'(1);
    localparam logic [act_type_size-1:0] ACT_LEAKY = act_type_size'(2);
    localparam logic [act_type_size-1:0] ACT_HSIG  = act_type_size'(3);

    localparam logic signed [data_size-1:0] ONE     = data_size'(ONE_I);
    localparam logic signed [data_size-1:0] QUARTER = data_size'(ONE_I >> 2);
    localparam logic signed [data_size-1:0] EIGHTH  = data_size'(ONE_I >> 3);
    localparam logic signed [data_size-1:0] TWO_POS = data_size'(2 * ONE_I);
    localparam logic signed [data_size-1:0] TWO_NEG = data_size'(-2 * ONE_I);
    localparam logic signed [data_size:0]   HALF_W  = (data_size + 1)'(ONE_I >> 1);
    localparam logic signed [data_size:0]   ONE_W   = (data_size + 1)'(ONE_I);

    logic [1:0]                        state_q, state_d;
    logic [IDXW-1:0]                   idx_q, idx_d;
    logic [data_size*size-1:0]         a_q, d_q, y_q, pred_q;
    logic [act_type_size-1:0]          act_q;
    logic [dense_type_size-1:0]        dense_q;
    logic [cost_type_size-1:0]         cost_q;
    logic [backprop_controll_size-1:0] bp_q;

    logic                        accept;
    logic signed [data_size-1:0] cur_x;
    logic signed [data_size:0]   x_w;
    logic signed [data_size:0]   hs_sum;
    logic                        x_pos;
    logic signed [data_size-1:0] elem_a, elem_d;

    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        cur_x  = $signed(y_q[int'(idx_q)*data_size +: data_size]);
        x_pos  = !cur_x[data_size-1] && (cur_x != '0);
        // Sign-extend by one bit so the hard-sigmoid offset cannot wrap before clamping.
        x_w    = {cur_x[data_size-1], cur_x};
        hs_sum = (x_w >>> 2) + HALF_W;
        elem_a = cur_x;
        elem_d = ONE;
        case (act_q)
            ACT_RELU: begin
                elem_a = x_pos ? cur_x : '0;
                elem_d = x_pos ? ONE : '0;
            end
            ACT_LEAKY: begin
                elem_a = x_pos ? cur_x : (cur_x >>> 3);
                elem_d = x_pos ? ONE : EIGHTH;
            end
            ACT_HSIG: begin
                if (hs_sum[data_size])
                    elem_a = '0;
                else if (hs_sum > ONE_W)
                    elem_a = ONE;
                else
                    elem_a = hs_sum[data_size-1:0];
                elem_d = ((cur_x > TWO_NEG) && (cur_x < TWO_POS)) ? QUARTER : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    idx_d   = '0;
                end
            end
            S_BUSY: begin
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            y_q     <= '0;
            pred_q  <= '0;
            act_q   <= '0;
            dense_q <= '0;
            cost_q  <= '0;
            bp_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                y_q     <= y;
                act_q   <= act_type;
                dense_q <= dense_type;
                cost_q  <= cost_type;
                pred_q  <= predict_value;
                bp_q    <= backprop_controll;
            end
            if (state_q == S_BUSY) begin
                a_q[int'(idx_q)*data_size +: data_size] <= elem_a;
                d_q[int'(idx_q)*data_size +: data_size] <= elem_d;
            end
        end
    end

    assign a_out                 = a_q;
    assign d_out                 = d_q;
    assign y_out                 = y_q;
    assign act_type_out          = act_q;
    assign dense_type_out        = dense_q;
    assign cost_type_out         = cost_q;
    assign predict_value_out     = pred_q;
    assign backprop_controll_out = bp_q;

endmodule

// File: tb/tb_activate_unit.sv
// Randomized self-checking bench for activate_unit against a behavioural model of the
// activation rules, handshake latency, backpressure, mid-operation reset and throughput.
module tb_activate_unit;

    localparam int SZ  = 3;
    localparam int DW  = 16;
    localparam int FB  = 8;
    localparam int AW  = 4;
    localparam int DTW = 4;
    localparam int CTW = 8;
    localparam int BPW = 66;
    localparam int VW  = SZ * DW;
    localparam int ONE = 1 << FB;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [AW-1:0]  act_type;
    logic [VW-1:0]  y;
    logic [DTW-1:0] dense_type;
    logic [CTW-1:0] cost_type;
    logic [VW-1:0]  predict_value;
    logic [BPW-1:0] backprop_controll;
    logic           out_valid;
    logic           out_ready;
    logic [VW-1:0]  a_out, d_out, y_out, predict_value_out;
    logic [AW-1:0]  act_type_out;
    logic [DTW-1:0] dense_type_out;
    logic [CTW-1:0] cost_type_out;
    logic [BPW-1:0] backprop_controll_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    activate_unit #(
        .size(SZ), .data_size(DW), .frac_bits(FB), .act_type_size(AW),
        .dense_type_size(DTW), .cost_type_size(CTW), .backprop_controll_size(BPW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .act_type(act_type), .y(y), .dense_type(dense_type), .cost_type(cost_type),
        .predict_value(predict_value), .backprop_controll(backprop_controll),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .d_out(d_out),
        .y_out(y_out), .act_type_out(act_type_out), .dense_type_out(dense_type_out),
        .cost_type_out(cost_type_out), .predict_value_out(predict_value_out),
        .backprop_controll_out(backprop_controll_out)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [AW-1:0] code, input logic [VW-1:0] yv,
                                  output logic [VW-1:0] a, output logic [VW-1:0] d);
        int x, ai, di, s;
        a = '0;
        d = '0;
        for (int unsigned i = 0; i < SZ; i++) begin
            x = int'($signed(yv[i*DW +: DW]));
            case (int'(code))
                1: begin
                    ai = (x > 0) ? x : 0;
                    di = (x > 0) ? ONE : 0;
                end
                2: begin
                    ai = (x > 0) ? x : (x >>> 3);
                    di = (x > 0) ? ONE : ONE / 8;
                end
                3: begin
                    s  = (x >>> 2) + ONE / 2;
                    ai = (s < 0) ? 0 : ((s > ONE) ? ONE : s);
                    di = (x > -2 * ONE && x < 2 * ONE) ? ONE / 4 : 0;
                end
                default: begin
                    ai = x;
                    di = ONE;
                end
            endcase
            a[i*DW +: DW] = ai[DW-1:0];
            d[i*DW +: DW] = di[DW-1:0];
        end
    endfunction

    function automatic logic [DW-1:0] rand_elem();
        case ($urandom_range(0, 8))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'h0200;
            4: return 16'hFE00;
            5: return 16'h01FF;
            6: return 16'hFE01;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int unsigned i = 0; i < SZ; i++) v[i*DW +: DW] = rand_elem();
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_sideband();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        dense_type        = DTW'($urandom);
        cost_type         = CTW'($urandom);
        predict_value     = w[VW-1:0];
        w = {$urandom, $urandom, $urandom};
        backprop_controll = w[BPW-1:0];
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".out_valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, ".a_out"}, 128'(a_out), 128'(0));
        check({tag, ".d_out"}, 128'(d_out), 128'(0));
        check({tag, ".y_out"}, 128'(y_out), 128'(0));
        check({tag, ".act_out"}, 128'(act_type_out), 128'(0));
        check({tag, ".dense_out"}, 128'(dense_type_out), 128'(0));
        check({tag, ".cost_out"}, 128'(cost_type_out), 128'(0));
        check({tag, ".pred_out"}, 128'(predict_value_out), 128'(0));
        check({tag, ".bp_out"}, 128'(backprop_controll_out), 128'(0));
    endtask

    // Accepts one vector, checks latency and the held result; optionally applies backpressure.
    task automatic run_one(input logic [AW-1:0] code, input logic [VW-1:0] yv,
                           input string tag, input int stall);
        logic [VW-1:0]  ea, ed, ey, ep;
        logic [DTW-1:0] edn;
        logic [CTW-1:0] ec;
        logic [BPW-1:0] eb;
        int lat, hs;
        model(code, yv, ea, ed);
        check({tag, ".in_ready_idle"}, 128'(in_ready), 128'(1'b1));
        act_type = code;
        y        = yv;
        rand_sideband();
        ey = yv; edn = dense_type; ec = cost_type; ep = predict_value; eb = backprop_controll;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        y        = rand_vec();
        act_type = AW'($urandom);
        rand_sideband();
        check({tag, ".in_ready_busy"}, 128'(in_ready), 128'(1'b0));
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), 128'(SZ));
        for (int k = 0; k <= stall; k++) begin
            check({tag, ".a_out"}, 128'(a_out), 128'(ea));
            check({tag, ".d_out"}, 128'(d_out), 128'(ed));
            check({tag, ".y_out"}, 128'(y_out), 128'(ey));
            check({tag, ".act_out"}, 128'(act_type_out), 128'(code));
            check({tag, ".dense_out"}, 128'(dense_type_out), 128'(edn));
            check({tag, ".cost_out"}, 128'(cost_type_out), 128'(ec));
            check({tag, ".pred_out"}, 128'(predict_value_out), 128'(ep));
            check({tag, ".bp_out"}, 128'(backprop_controll_out), 128'(eb));
            if (k < stall) begin
                check({tag, ".in_ready_stall"}, 128'(in_ready), 128'(1'b0));
                check({tag, ".out_valid_stall"}, 128'(out_valid), 128'(1'b1));
                in_valid = 1'($urandom);
                y        = rand_vec();
                rand_sideband();
                tick();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid && out_ready) hs++;
            if (k == 1) check({tag, ".in_ready_after"}, 128'(in_ready), 128'(1'b1));
            tick();
        end
        out_ready = 1'b0;
        check({tag, ".handshakes"}, 128'(hs), 128'(1));
        check({tag, ".out_valid_after"}, 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] qa[$], qd[$], qy[$];
        logic [VW-1:0] ea, ed;
        logic          acc, ov;
        int            last_acc, cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        act_type = '0; y = '0; dense_type = '0; cost_type = '0;
        predict_value = '0; backprop_controll = '0;
        #3;
        check("rst.in_ready", 128'(in_ready), 128'(1'b0));
        check_zero_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel.in_ready", 128'(in_ready), 128'(1'b1));
        check_zero_outputs("rel");

        run_one(4'd1, {16'h0000, 16'hFF00, 16'h0200}, "relu", 0);
        run_one(4'd2, {16'h0000, 16'hFF00, 16'h0200}, "leaky", 0);
        run_one(4'd3, {16'h0000, 16'hFF00, 16'h0200}, "hsig_a", 0);
        run_one(4'd3, {16'h0100, 16'h8000, 16'h7FFF}, "hsig_b", 0);
        run_one(4'd7, {16'hFFFF, 16'h1234, 16'h8000}, "code7", 0);
        run_one(4'd1, rand_vec(), "backpressure", 10);
        for (int n = 0; n < 20; n++) run_one(AW'($urandom), rand_vec(), "rand", $urandom_range(0, 3));

        // Reset while BUSY
        act_type = 4'd0; y = rand_vec(); rand_sideband(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready", 128'(in_ready), 128'(1'b0));
        check_zero_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst.in_ready_rel", 128'(in_ready), 128'(1'b1));
        check_zero_outputs("midrst_rel");

        // Back-to-back with in_valid and out_ready held high
        last_acc = -1;
        act_type = AW'($urandom); y = rand_vec(); rand_sideband();
        in_valid = 1'b1; out_ready = 1'b1;
        for (cyc = 0; cyc < 70; cyc++) begin
            if (cyc == 55) in_valid = 1'b0;
            acc = in_valid && in_ready;
            ov  = out_valid && out_ready;
            if (ov) begin
                if (qa.size() == 0) begin
                    check("b2b.unexpected_out", 128'(1), 128'(0));
                end else begin
                    check("b2b.a_out", 128'(a_out), 128'(qa.pop_front()));
                    check("b2b.d_out", 128'(d_out), 128'(qd.pop_front()));
                    check("b2b.y_out", 128'(y_out), 128'(qy.pop_front()));
                end
            end
            tick();
            if (acc) begin
                model(act_type, y, ea, ed);
                qa.push_back(ea); qd.push_back(ed); qy.push_back(y);
                if (last_acc >= 0) check("b2b.interval", 128'(cyc - last_acc), 128'(SZ + 2));
                last_acc = cyc;
                act_type = AW'($urandom); y = rand_vec(); rand_sideband();
            end
        end
        check("b2b.drained", 128'(qa.size()), 128'(0));
        check("b2b.accepted_some", 128'(last_acc > 0), 128'(1'b1));
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
